sensor_request_scheduler: RTL and testbench
===========================================

# sensor_request_scheduler

Request scheduler in front of the sensor connection slots: one serialized command stream shares `NUM_SENSORS` sensor slots. The block accepts a command/address pair from the UART receive path and routes it to the addressed slot. It holds that slot's enable and command stable until the slot reports data, then hands one response frame to the UART transmit path. It also owns continuous-sensing sessions (commands 0x03/0x04 through stop 0x05/0x06) and a per-transaction watchdog.

## Interface
Parameters:
- `NUM_SENSORS`, 4: number of sensor slots. Legal addresses are 0..NUM_SENSORS-1.
- `TIMEOUT_CYCLES`, 150_000_000: watchdog limit, 3 s at 50 MHz. Must exceed the 2 s continuous period.

Ports:
- `clock` in 1: single clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request pair present.
- `req_command` in 8: requested command code.
- `req_address` in 8: target slot.
- `req_ready` out 1: request accepted on the cycle where `req_valid && req_ready`.
- `sensor_enable` out NUM_SENSORS: one-hot enable, at most one bit high.
- `sensor_command` out 8: registered command, broadcast to all slots.
- `sensor_done` in NUM_SENSORS: per-slot "data can be sent" level.
- `sensor_resp_command` in 8*NUM_SENSORS: slot i response command at [8i+7:8i].
- `sensor_resp_value` in 8*NUM_SENSORS: slot i response value at [8i+7:8i].
- `tx_valid` out 1: response frame pending.
- `tx_command` out 8: frame command byte.
- `tx_value` out 8: frame value byte.
- `tx_ready` in 1: frame consumed on the cycle where `tx_valid && tx_ready`.
- `overrun_count` out 8: saturating count of stream frames overwritten before they were consumed.

## Operation
States: IDLE, WAIT, SEND, STREAM.
- **IDLE**
  - `req_ready`=1.
  - On accept with `req_address` >= NUM_SENSORS:
    - frame `0xEF`/`req_address`;
    - no enable;
    - go to SEND.
  - On accept with a valid address:
    - latch `sel` and `sensor_command` <= `req_command`;
    - `sensor_enable[sel]` <= 1;
    - clear watchdog;
    - clear `done_prev`;
    - go to STREAM if the command is 0x03/0x04, otherwise to WAIT.
- **WAIT**
  - On a rising edge of `sensor_done[sel]` (current=1, `done_prev`=0):
    - capture the slot's response into `tx_command`/`tx_value`;
    - `tx_valid` <= 1;
    - `sensor_enable` <= 0;
    - go to SEND.
- **SEND**
  - Hold `tx_*` stable.
  - On `tx_ready`: `tx_valid` <= 0, go to IDLE.
- **STREAM**
  - Enable stays high.
  - Each rising edge of `sensor_done[sel]`:
    - loads the frame and sets `tx_valid`;
    - clears the watchdog.
  - If `tx_valid` is already high at that edge, the frame is overwritten with the newest data and `overrun_count` increments, saturating at 0xFF.
  - `req_ready` = !`tx_valid`.
  - Accepted request with `req_address`==`sel` and command 0x05/0x06:
    - `sensor_enable` <= 0;
    - `sensor_command` <= the stop code;
    - frame `0x0A`/`sel`;
    - go to SEND.
  - Any other accepted request:
    - frame `0xFF`/`0xFF`;
    - stay in STREAM.
- **Watchdog**
  - Counts in WAIT and STREAM.
  - When it reaches TIMEOUT_CYCLES:
    - `sensor_enable` <= 0;
    - frame `0x1F`/`0x1F`;
    - go to SEND.
  - Timeout has priority over a done edge in the same cycle.
- `done_prev` samples `sensor_done[sel]` every cycle. A done level that is already high at dispatch is not treated as an edge.
- Stop 0x05/0x06 received in IDLE is dispatched as an ordinary one-shot; the slot's own 0xAA reply is forwarded unchanged.

## Timing
- Reset values: `req_ready`=0 while `reset` is high and 1 in the first cycle after. All other outputs are 0. State is IDLE. Watchdog and `overrun_count` are 0.
- Reset mid-transaction: outputs return to reset values on the next edge, and any pending frame is lost.
- Dispatch latency: the accept edge produces `sensor_enable`/`sensor_command` visible in the next cycle.
- Response latency: the done rising edge is sampled at edge E. `tx_valid` and `sensor_enable`=0 are visible after E.
- Invalid-address frame: `tx_valid` is visible one cycle after accept.
- `sensor_command` and `sel` never change while enable is high, except on the stop transition.
- Watchdog width is ceil(log2(TIMEOUT_CYCLES+1)), which is 28 bits at the default.

## Test plan
- One-shot read: accept 0x01/addr 2; slot 2 raises done with 0x09/0x19 after 1000 cycles. Required: `sensor_enable`=4'b0100 during the wait, then frame 0x09/0x19, then enable 0, back in IDLE after `tx_ready`.
- Invalid address: accept 0x02/addr 7 with NUM_SENSORS=4. Required: frame 0xEF/0x07 and no enable bit ever high.
- Stream with backpressure: accept 0x03/addr 0; slot 0 produces 3 done edges while `tx_ready`=0. Required: frame shows the 3rd data, `overrun_count`=2.
- Stream rejection and stop: while streaming on addr 0, send 0x01/addr 1, then 0x05/addr 0. Required: frame 0xFF/0xFF, then frame 0x0A/0x00, enable 0, IDLE.
- Timeout: with TIMEOUT_CYCLES=100, accept 0x00/addr 1 and never raise done. Required: frame 0x1F/0x1F on the 100th wait cycle, enable dropped.
- Reset mid-WAIT: assert `reset` one cycle. Required: all outputs 0 next cycle, `req_ready`=1 the cycle after `reset` falls.

Source files
------------

// File: rtl/sensor_request_scheduler.sv
// sensor_request_scheduler: routes command/address pairs to one of NUM_SENSORS slots and returns one response frame per transaction,
// with continuous-sensing sessions and a per-transaction watchdog.
module sensor_request_scheduler #(
  parameter int NUM_SENSORS = 4,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [7:0]               req_command,
  input  logic [7:0]               req_address,
  output logic                     req_ready,
  output logic [NUM_SENSORS-1:0]   sensor_enable,
  output logic [7:0]               sensor_command,
  input  logic [NUM_SENSORS-1:0]   sensor_done,
  input  logic [8*NUM_SENSORS-1:0] sensor_resp_command,
  input  logic [8*NUM_SENSORS-1:0] sensor_resp_value,
  output logic                     tx_valid,
  output logic [7:0]               tx_command,
  output logic [7:0]               tx_value,
  input  logic                     tx_ready,
  output logic [7:0]               overrun_count
);
  localparam int SW = NUM_SENSORS > 1 ? $clog2(NUM_SENSORS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT, SEND, STREAM} state_t;
  state_t state, state_n;
  logic [SW-1:0] sel, sel_n, req_sel;
  logic [NUM_SENSORS-1:0] enable_n;
  logic [7:0] command_n, tx_command_n, tx_value_n, overrun_n;
  logic tx_valid_n, done_prev, done_prev_n;
  logic [TW-1:0] wdog, wdog_n;
  logic accept, rise, timeout, addr_ok, stop, busy;
  assign req_sel = req_address[SW-1:0];
  assign req_ready = !reset && (state == IDLE || (state == STREAM && !tx_valid));
  assign accept = req_valid && req_ready;
  assign addr_ok = {24'd0, req_address} < 32'(NUM_SENSORS);
  assign rise = sensor_done[sel] && !done_prev;
  assign busy = state == WAIT || state == STREAM;
  assign timeout = busy && wdog == TW'(TIMEOUT_CYCLES - 1);
  assign stop = req_address == 8'(sel) && (req_command == 8'h05 || req_command == 8'h06);
  always_comb begin
    state_n = state;
    sel_n = sel;
    enable_n = sensor_enable;
    command_n = sensor_command;
    tx_valid_n = tx_valid;
    tx_command_n = tx_command;
    tx_value_n = tx_value;
    overrun_n = overrun_count;
    wdog_n = busy ? wdog + 1'b1 : wdog;
    done_prev_n = sensor_done[sel];
    case (state)
      IDLE: if (accept) begin
        if (!addr_ok) begin
          tx_valid_n = 1'b1;
          tx_command_n = 8'hEF;
          tx_value_n = req_address;
          state_n = SEND;
        end else begin
          sel_n = req_sel;
          enable_n = NUM_SENSORS'(1) << req_sel;
          command_n = req_command;
          wdog_n = '0;
          // a level already high at dispatch must not count as a done edge
          done_prev_n = sensor_done[req_sel];
          state_n = (req_command == 8'h03 || req_command == 8'h04) ? STREAM : WAIT;
        end
      end
      WAIT: if (timeout) begin
        enable_n = '0;
        tx_valid_n = 1'b1;
        tx_command_n = 8'h1F;
        tx_value_n = 8'h1F;
        state_n = SEND;
      end else if (rise) begin
        enable_n = '0;
        tx_valid_n = 1'b1;
        tx_command_n = sensor_resp_command[{sel, 3'b000} +: 8];
        tx_value_n = sensor_resp_value[{sel, 3'b000} +: 8];
        state_n = SEND;
      end
      SEND: if (tx_ready) begin
        tx_valid_n = 1'b0;
        state_n = IDLE;
      end
      STREAM: begin
        if (tx_valid && tx_ready) tx_valid_n = 1'b0;
        if (timeout) begin
          enable_n = '0;
          tx_valid_n = 1'b1;
          tx_command_n = 8'h1F;
          tx_value_n = 8'h1F;
          state_n = SEND;
        end else if (accept && stop) begin
          enable_n = '0;
          command_n = req_command;
          tx_valid_n = 1'b1;
          tx_command_n = 8'h0A;
          tx_value_n = 8'(sel);
          state_n = SEND;
        end else if (accept) begin
          tx_valid_n = 1'b1;
          tx_command_n = 8'hFF;
          tx_value_n = 8'hFF;
        end else if (rise) begin
          tx_valid_n = 1'b1;
          tx_command_n = sensor_resp_command[{sel, 3'b000} +: 8];
          tx_value_n = sensor_resp_value[{sel, 3'b000} +: 8];
          wdog_n = '0;
          overrun_n = (tx_valid && !tx_ready && overrun_count != 8'hFF) ? overrun_count + 8'd1 : overrun_count;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      sensor_enable <= '0;
      sensor_command <= '0;
      tx_valid <= 1'b0;
      tx_command <= '0;
      tx_value <= '0;
      overrun_count <= '0;
      wdog <= '0;
      done_prev <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      sensor_enable <= enable_n;
      sensor_command <= command_n;
      tx_valid <= tx_valid_n;
      tx_command <= tx_command_n;
      tx_value <= tx_value_n;
      overrun_count <= overrun_n;
      wdog <= wdog_n;
      done_prev <= done_prev_n;
    end
  end
endmodule

// File: tb/tb_sensor_request_scheduler.sv
// tb_sensor_request_scheduler: directed bench with an expected-frame queue for sensor_request_scheduler
module tb_sensor_request_scheduler;
  localparam int NS = 4;
  localparam int TO = 1500;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic [7:0] req_command = '0, req_address = '0;
  logic req_ready;
  logic [NS-1:0] sensor_enable;
  logic [7:0] sensor_command;
  logic [NS-1:0] sensor_done = '0;
  logic [8*NS-1:0] resp_cmd = '0, resp_val = '0;
  logic tx_valid, tx_ready = 1'b0;
  logic [7:0] tx_command, tx_value, overrun_count;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];

  sensor_request_scheduler #(.NUM_SENSORS(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_command(req_command), .req_address(req_address), .req_ready(req_ready),
    .sensor_enable(sensor_enable), .sensor_command(sensor_command), .sensor_done(sensor_done),
    .sensor_resp_command(resp_cmd), .sensor_resp_value(resp_val),
    .tx_valid(tx_valid), .tx_command(tx_command), .tx_value(tx_value), .tx_ready(tx_ready),
    .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_command = c;
    req_address = a;
    while (!req_ready && n < 100) begin tick(); n++; end
    chk("req_accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag);
    int n = 0;
    logic [15:0] e;
    while (!tx_valid && n < 2000) begin tick(); n++; end
    chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 16'hxxxx;
    chk(tag, {16'd0, tx_command, tx_value}, {16'd0, e});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic set_resp(input int s, input logic [7:0] c, input logic [7:0] v);
    resp_cmd[8*s +: 8] = c;
    resp_val[8*s +: 8] = v;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_outputs", {tx_valid, overrun_count, sensor_command, tx_command, tx_value, sensor_enable}, '0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

    // one-shot read on slot 2
    send(8'h01, 8'd2);
    chk("oneshot_enable", {28'd0, sensor_enable}, 32'b0100);
    chk("oneshot_command", {24'd0, sensor_command}, 32'h01);
    repeat (500) tick();
    chk("oneshot_wait_enable", {28'd0, sensor_enable}, 32'b0100);
    chk("oneshot_wait_tx", {31'd0, tx_valid}, 32'd0);
    repeat (500) tick();
    set_resp(2, 8'h09, 8'h19);
    sensor_done[2] = 1'b1;
    exp_q.push_back(16'h0919);
    tick();
    chk("oneshot_tx_latency", {31'd0, tx_valid}, 32'd1);
    chk("oneshot_enable_off", {28'd0, sensor_enable}, 32'd0);
    expect_frame("oneshot_frame");
    sensor_done[2] = 1'b0;
    chk("oneshot_idle", {31'd0, req_ready}, 32'd1);

    // invalid address
    send(8'h02, 8'd7);
    exp_q.push_back(16'hEF07);
    chk("badaddr_tx_latency", {31'd0, tx_valid}, 32'd1);
    chk("badaddr_enable", {28'd0, sensor_enable}, 32'd0);
    expect_frame("badaddr_frame");
    chk("badaddr_enable_after", {28'd0, sensor_enable}, 32'd0);

    // stream with backpressure: three done edges, no consumption
    send(8'h03, 8'd0);
    chk("stream_enable", {28'd0, sensor_enable}, 32'b0001);
    for (int k = 0; k < 3; k++) begin
      set_resp(0, 8'h30 + 8'(k), 8'h40 + 8'(k));
      sensor_done[0] = 1'b1;
      tick();
      sensor_done[0] = 1'b0;
      tick();
    end
    exp_q.push_back(16'h3242);
    chk("stream_overrun", {24'd0, overrun_count}, 32'd2);
    expect_frame("stream_frame");
    chk("stream_enable_hold", {28'd0, sensor_enable}, 32'b0001);

    // rejection, then stop
    send(8'h01, 8'd1);
    exp_q.push_back(16'hFFFF);
    expect_frame("reject_frame");
    chk("reject_enable_hold", {28'd0, sensor_enable}, 32'b0001);
    chk("reject_command_hold", {24'd0, sensor_command}, 32'h03);
    send(8'h05, 8'd0);
    exp_q.push_back(16'h0A00);
    chk("stop_enable_off", {28'd0, sensor_enable}, 32'd0);
    chk("stop_command", {24'd0, sensor_command}, 32'h05);
    expect_frame("stop_frame");
    chk("stop_idle", {31'd0, req_ready}, 32'd1);

    // stop code in IDLE is an ordinary one-shot
    send(8'h06, 8'd3);
    chk("idle_stop_enable", {28'd0, sensor_enable}, 32'b1000);
    set_resp(3, 8'hAA, 8'h03);
    sensor_done[3] = 1'b1;
    exp_q.push_back(16'hAA03);
    tick();
    expect_frame("idle_stop_frame");
    sensor_done[3] = 1'b0;

    // watchdog
    send(8'h00, 8'd1);
    chk("timeout_enable", {28'd0, sensor_enable}, 32'b0010);
    repeat (TO - 1) tick();
    chk("timeout_not_yet", {31'd0, tx_valid}, 32'd0);
    tick();
    exp_q.push_back(16'h1F1F);
    chk("timeout_fire", {31'd0, tx_valid}, 32'd1);
    chk("timeout_enable_off", {28'd0, sensor_enable}, 32'd0);
    expect_frame("timeout_frame");

    // reset in WAIT
    send(8'h01, 8'd2);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("midrst_outputs", {tx_valid, sensor_command, sensor_enable}, '0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_release_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("midrst_tx_idle", {31'd0, tx_valid}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
